// File: rtl/sobel_tx_collector.sv
// Collects Sobel result bytes of one frame into a small FIFO and streams them to a UART transmitter.
// Optional build macro SOBEL_THRESH_EN binarizes each byte against THRESH before it is buffered.
module sobel_tx_collector #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned THRESH     = 200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] W,
  input  logic [15:0] H,
  input  logic [7:0]  data_in,
  input  logic        transmit_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic [31:0] byte_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   n_q, n_d;
  logic [31:0]   rcv_q, rcv_d;
  logic [31:0]   byte_cnt_q, byte_cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic [PW-1:0] occ;
  logic          full;
  logic          pop;
  logic          push;
  logic          wr_en;
  logic [7:0]    push_byte;
  logic [31:0]   n_calc;
  logic          degenerate;

`ifdef SOBEL_THRESH_EN
  assign push_byte = (32'(data_in) >= THRESH) ? 8'hFF : 8'h00;
`else
  logic [31:0] thresh_unused;
  assign thresh_unused = THRESH;
  assign push_byte     = data_in;
`endif

  assign occ        = wr_q - rd_q;
  assign full       = (occ == PW'(FIFO_DEPTH));
  assign degenerate = (W < 16'd3) || (H < 16'd3);
  assign n_calc     = 32'(W - 16'd2) * 32'(H - 16'd2);

  // Next-state: FIFO bookkeeping first, then frame sequencing overrides on start.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rcv_d      = rcv_q;
    byte_cnt_d = byte_cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;
    pop        = tx_valid_q && tx_ready;
    push       = (state_q == COLLECT) && transmit_valid;

    if (pop) begin
      rd_d       = rd_q + PW'(1);
      byte_cnt_d = byte_cnt_q + 32'd1;
    end
    // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
    if (push) begin
      rcv_d = rcv_q + 32'd1;
      if (!full || pop) begin
        wr_en = 1'b1;
        wr_d  = wr_q + PW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d        = degenerate ? 32'd0 : n_calc;
          rcv_d      = 32'd0;
          byte_cnt_d = 32'd0;
          wr_d       = '0;
          rd_d       = '0;
          state_d    = degenerate ? DONE : COLLECT;
        end
      end
      COLLECT: if (push && (rcv_d == n_q)) state_d = FLUSH;
      FLUSH:   if (occ == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == COLLECT) || (state_d == FLUSH);
    tx_valid_d = busy_d && (wr_d != rd_d);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      n_q        <= 32'd0;
      rcv_q      <= 32'd0;
      byte_cnt_q <= 32'd0;
      wr_q       <= '0;
      rd_q       <= '0;
      ovf_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rcv_q      <= rcv_d;
      byte_cnt_q <= byte_cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ovf_q      <= ovf_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Storage is reset so the head byte reads 8'h00 while rstn is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= push_byte;
    end
  end

  assign tx_data    = mem_q[rd_q[AW-1:0]];
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign byte_count = byte_cnt_q;

endmodule

// File: tb/tb_sobel_tx_collector.sv
// Randomized self-checking bench for sobel_tx_collector against a queue-based frame model.
`timescale 1ns/1ps
module tb_sobel_tx_collector;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned THR   = 200;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] W = 16'd0;
  logic [15:0] H = 16'd0;
  logic [7:0]  data_in = 8'h00;
  logic        transmit_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic [31:0] byte_count;

  sobel_tx_collector #(.FIFO_DEPTH(DEPTH), .THRESH(THR)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .W              (W),
    .H              (H),
    .data_in        (data_in),
    .transmit_valid (transmit_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .frame_done     (frame_done),
    .overflow       (overflow),
    .byte_count     (byte_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: expected byte queue plus frame bookkeeping.
  logic [7:0] mq[$];
  int   m_n = 0, m_rcv = 0, m_bytes = 0;
  bit   m_active = 1'b0, m_ovf = 1'b0;
  int   fd_cnt = 0, fd_base = 0;
  bit   stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xform(input logic [7:0] d);
`ifdef SOBEL_THRESH_EN
    return (32'(d) >= THR) ? 8'hFF : 8'h00;
`else
    return d;
`endif
  endfunction

  // One clock: compare outputs to the model, advance the model, then cross the edge.
  task automatic step();
    bit exp_v;
    bit pop;
    exp_v = m_active && (mq.size() > 0);
    check("tx_valid", 32'(tx_valid), 32'(exp_v));
    if (stall_prev && tx_valid) check("stall_hold", 32'(tx_data), 32'(data_prev));
    stall_prev = tx_valid && !tx_ready;
    data_prev  = tx_data;
    pop = exp_v && tx_ready;
    if (pop) begin
      check("tx_data", 32'(tx_data), 32'(mq[0]));
      void'(mq.pop_front());
      m_bytes++;
    end
    if (m_active && (m_rcv < m_n) && transmit_valid) begin
      m_rcv++;
      if (mq.size() < int'(DEPTH)) mq.push_back(xform(data_in));
      else m_ovf = 1'b1;
    end
    if (m_active && (m_rcv == m_n) && (mq.size() == 0)) m_active = 1'b0;
    if (start && !m_active) begin
      m_n = ((W < 16'd3) || (H < 16'd3)) ? 0 : (int'(W) - 2) * (int'(H) - 2);
      mq.delete();
      m_rcv    = 0;
      m_bytes  = 0;
      m_active = (m_n != 0);
    end
    @(posedge clk);
    @(negedge clk);
    if (frame_done) fd_cnt++;
  endtask

  task automatic drive(input bit s, input bit v, input logic [7:0] d, input bit r);
    start          = s;
    transmit_valid = v;
    data_in        = d;
    tx_ready       = r;
    step();
  endtask

  task automatic begin_frame(input int w, input int h, input bit r);
    W       = 16'(w);
    H       = 16'(h);
    fd_base = fd_cnt;
    drive(1'b1, 1'b0, 8'h00, r);
  endtask

  task automatic wait_done(input string tag, input int budget, input int rdy_pct);
    int c;
    c = 0;
    while ((fd_cnt == fd_base) && (c < budget)) begin
      drive(1'b0, 1'b0, 8'h00, int'($urandom_range(99)) < rdy_pct);
      c++;
    end
    check({tag, "_done"}, 32'(fd_cnt - fd_base), 32'd1);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
    check({tag, "_pulse1"}, 32'(fd_cnt - fd_base), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bytes"}, byte_count, 32'(m_bytes));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_byte_count", byte_count, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    mq.delete();
    m_active = 1'b0; m_ovf = 1'b0; m_bytes = 0; m_rcv = 0; m_n = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int fd0;

    // Power-on reset values.
    @(negedge clk);
    @(negedge clk);
    check("por_tx_valid", 32'(tx_valid), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    check("por_frame_done", 32'(frame_done), 32'd0);
    check("por_tx_data", 32'(tx_data), 32'd0);
    check("por_byte_count", byte_count, 32'd0);
    check("por_overflow", 32'(overflow), 32'd0);
    rstn = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // 5x4 frame, six bytes, receiver always ready.
    begin_frame(5, 4, 1'b1);
    check("s1_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 6; i++) drive(1'b0, 1'b1, 8'(i), 1'b1);
    wait_done("s1", 50, 100);
    check("s1_count6", byte_count, 32'd6);

    // Full FIFO with a simultaneous push and pop.
    begin_frame(7, 6, 1'b0);
    for (int i = 1; i <= 16; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
    check("s2_full_noovf", 32'(overflow), 32'd0);
    drive(1'b0, 1'b1, 8'd17, 1'b1);
    for (int i = 18; i <= 20; i++) drive(1'b0, 1'b1, 8'(i), 1'b1);
    wait_done("s2", 100, 100);
    check("s2_count20", byte_count, 32'd20);
    check("s2_noovf", 32'(overflow), 32'd0);

    // Twenty pushes into a stalled 16-deep FIFO.
    begin_frame(6, 7, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("s3_ovf", 32'(overflow), 32'd1);
    check("s3_held_tx_valid", 32'(tx_valid), 32'd1);
    wait_done("s3", 100, 100);
    check("s3_count16", byte_count, 32'd16);

    // tx_ready toggling, plus an ignored start mid-frame.
    begin_frame(6, 5, 1'b0);
    for (int c = 0; (c < 500) && (m_rcv < m_n); c++)
      drive(c == 3, int'($urandom_range(99)) < 70, 8'($urandom), c[0]);
    wait_done("s4", 200, 50);
    check("s4_count12", byte_count, 32'd12);

    // Reset mid-frame after three bytes, then a clean frame.
    begin_frame(5, 4, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom), 1'b1);
    async_reset();
    fd0 = fd_cnt;
    repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("s5_no_done", 32'(fd_cnt - fd0), 32'd0);
    begin_frame(5, 4, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'($urandom), 1'b1);
    wait_done("s5", 50, 100);
    check("s5_count6", byte_count, 32'd6);

    // Degenerate width: immediate frame_done, no bytes.
    begin_frame(2, 9, 1'b1);
    wait_done("s6", 3, 100);
    check("s6_count0", byte_count, 32'd0);

`ifdef SOBEL_THRESH_EN
    // Binarization around the threshold.
    begin_frame(5, 3, 1'b1);
    drive(1'b0, 1'b1, 8'd199, 1'b1);
    drive(1'b0, 1'b1, 8'd200, 1'b1);
    drive(1'b0, 1'b1, 8'd255, 1'b1);
    wait_done("s7", 50, 100);
`endif

    // Random frames with random valid/ready activity.
    for (int f = 0; f < 6; f++) begin
      begin_frame(int'($urandom_range(8, 2)), int'($urandom_range(8, 3)), 1'b1);
      for (int c = 0; (c < 3000) && (m_rcv < m_n); c++)
        drive(1'b0, int'($urandom_range(99)) < 70, 8'($urandom),
              int'($urandom_range(99)) < 60);
      wait_done("rnd", 500, 60);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
